c3lib_ckmux4_sel_ctrl: RTL

C3LIB_CKMUX4_SEL_CTRL -- requirements
Module: c3lib_ckmux4_sel_ctrl

---
 rtl/c3lib_ckmux4_sel_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/c3lib_ckmux4_sel_ctrl.sv
// Glitch-free select sequencer for a 4:1 clock mux: gates the downstream clock off,
// moves the selects while gated, lets the mux settle, then re-enables the gate.
module c3lib_ckmux4_sel_ctrl #(
  parameter int         OFF_CYC    = 4,
  parameter int         SETTLE_CYC = 4,
  parameter logic [1:0] RST_SEL    = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_vld,
  input  logic [1:0] req_sel,
  output logic       req_rdy,
  input  logic       tst_override,
  output logic       s0,
  output logic       s1,
  output logic       ck_gate_en,
  output logic       busy,
  output logic       sw_done
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GATE_OFF = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [3:0] OFF_LOAD    = 4'(OFF_CYC - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t     r_state, w_state;
  logic [3:0] r_cnt, w_cnt;
  logic [1:0] r_sel, w_sel;
  logic [1:0] r_req_sel, w_req_sel;
  logic       r_gate, w_gate;
  logic       r_done, w_done;
  logic       w_accept;

  assign req_rdy    = (r_state == ST_IDLE) & ~tst_override;
  assign busy       = (r_state != ST_IDLE);
  assign w_accept   = req_vld & req_rdy;
  assign s0         = r_sel[0];
  assign s1         = r_sel[1];
  assign ck_gate_en = r_gate;
  assign sw_done    = r_done;

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_sel     <= RST_SEL;
      r_req_sel <= RST_SEL;
      r_gate    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_sel     <= w_sel;
      r_req_sel <= w_req_sel;
      r_gate    <= w_gate;
      r_done    <= w_done;
    end
  end

  // Next-state and next-output decode; selects move only while the gate is already off.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_sel     = r_sel;
    w_req_sel = r_req_sel;
    w_gate    = r_gate;
    w_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_req_sel = req_sel;
          if (req_sel == r_sel) begin
            w_state = ST_DONE;
            w_done  = 1'b1;
          end else begin
            w_state = ST_GATE_OFF;
            w_gate  = 1'b0;
            w_cnt   = OFF_LOAD;
          end
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_GATE_OFF: begin
        if (r_cnt == 4'd0) begin
          w_state = ST_SETTLE;
          w_sel   = r_req_sel;
          w_cnt   = SETTLE_LOAD;
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_state = ST_DONE;
          w_gate  = 1'b1;
          w_done  = 1'b1;
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
        w_gate  = 1'b1;
        w_cnt   = 4'd0;
      end
    endcase
  end

endmodule
